pwm_cfg_sequencer: RTL and testbench
====================================

Name: pwm_cfg_sequencer

Overview:
- Run-time configuration and start/stop controller for the 8-carrier 16-bit PWM core.
- Holds per-channel shadow registers (period, compare, initcarr) written from the register interface.
- Commits shadow to active values glitch-free on each channel's carrier event.
- Sequences PWM enable/disable: load on start, drain to a carrier boundary on stop.
- Sits between the AXI register bank and the cpwm_16bits_8carr inputs period_x, compare_x, initcarr_x and pwm_onoff.

Parameters:
PWM_WIDTH, 8, number of carrier channels
PWMCOUNT_WIDTH, 16, width of the period/compare/initcarr counters
DRAIN_TIMEOUT, 65535, maximum DRAIN cycles before a forced stop

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accepted when high together with wr_valid
wr_chan  in  3  target channel
wr_field  in  2  0=period, 1=compare, 2=initcarr, 3=reserved
wr_data  in  PWMCOUNT_WIDTH  write data
commit_req  in  1  commit pulse
commit_mask  in  PWM_WIDTH  channels to commit
commit_busy  out  1  OR of the pending mask
commit_done  out  1  one-cycle pulse when the pending mask drains to zero
start_req  in  1  start PWM
stop_req  in  1  stop PWM
carr_evt_x  in  PWM_WIDTH  per-channel carrier-event pulse from the PWM core
period_x  out  PWMCOUNT_WIDTH*PWM_WIDTH  active periods, channel i at [16i+15:16i]
compare_x  out  PWMCOUNT_WIDTH*PWM_WIDTH  active compare values
initcarr_x  out  PWMCOUNT_WIDTH*PWM_WIDTH  active initial carrier values
pwm_onoff  out  1  1=PWM_ON
seq_state  out  2  current FSM state
timeout_err  out  1  sticky; set on drain timeout

Behaviour:
- Reset (reset=0, asynchronous): all shadow and active registers 0, pending 0, pwm_onoff 0, seq_state SEQ_IDLE, commit_done 0, timeout_err 0, drain counter 0.
- Writes:
  - wr_ready = ~pending[wr_chan], combinational.
  - An accepted write updates the shadow register at that clock edge. Field 3 is accepted and ignored.
  - Writes never touch active registers directly.
- Commit acceptance:
  - commit_req is accepted only when commit_busy=0. If busy, the request is dropped with no merge.
  - On acceptance, pending <= commit_mask.
  - mask=0: commit_done pulses on the next cycle.
  - A write and commit_req in the same cycle: the write lands first, so the commit applies the new value.
- Commit application:
  - In SEQ_IDLE or SEQ_START, every pending channel copies shadow to active on the next edge, then its pending bit clears.
  - In SEQ_RUN, channel i copies when carr_evt_x[i]=1 and pending[i]=1. The new value is visible on the outputs in the cycle after the event.
  - In SEQ_DRAIN, pending bits are held and applied on the first cycle in SEQ_IDLE.
  - commit_done pulses for one cycle when pending transitions from nonzero to zero.
- FSM:
  - SEQ_IDLE: start_req -> SEQ_START, and timeout_err clears. stop_req is ignored.
  - SEQ_START (one cycle): all 8 channels force-copy shadow to active; pending clears, with commit_done pulsing if pending was nonzero. Next state SEQ_RUN, with pwm_onoff <= 1.
    - Latency: start_req at cycle n -> active registers loaded and pwm_onoff=1 visible at n+2.
  - SEQ_RUN: stop_req -> SEQ_DRAIN. start_req is ignored. If both requests arrive together, stop wins.
  - SEQ_DRAIN:
    - On entry, the seen mask is initialised to 1 for each channel whose active period is 0.
    - Each carr_evt_x[i] sets seen[i].
    - When seen is all ones: -> SEQ_IDLE with pwm_onoff <= 0.
    - When the drain counter reaches DRAIN_TIMEOUT: timeout_err <= 1, -> SEQ_IDLE with pwm_onoff <= 0.
    - The drain counter clears on entry to SEQ_DRAIN. start_req and stop_req are ignored here.
- Edge cases:
  - A period value of 0 is passed through unmodified.
  - Reset asserted mid-DRAIN or mid-commit returns everything to reset values immediately.
  - carr_evt_x is ignored outside SEQ_RUN and SEQ_DRAIN.

Decomposition:
- PKG_pwm additions:
  - typedef enum logic [1:0] _seq_state {SEQ_IDLE, SEQ_START, SEQ_RUN, SEQ_DRAIN}
  - typedef enum logic [1:0] _cfg_field {FLD_PERIOD, FLD_COMPARE, FLD_INITCARR, FLD_RSVD}
  - `DRAIN_TIMEOUT_DEF
- Sub-module pwm_cfg_channel:
  - Holds one channel's shadow and active triple plus its pending bit.
  - Inputs: write strobe/field/data, commit_set, apply.
  - Instantiated PWM_WIDTH times by a generate loop.
- The top level holds the FSM, the drain counter and the seen mask.

Test Plan:
- Reset then SEQ_IDLE write: ch0 period=2000, compare=500, initcarr=1000, commit mask=8'h01 -> period_x[15:0]=2000 one cycle later; commit_done pulses once; pwm_onoff stays 0.
- start_req at cycle n -> seq_state=SEQ_START at n+1; pwm_onoff=1 and all 8 channels' active values equal shadow at n+2.
- In SEQ_RUN:
  - Write ch3 compare=700 and commit mask 8'h08 -> compare_x[63:48] unchanged until carr_evt_x[3], then 700 on the next cycle.
  - wr_ready=0 for ch3 while pending; a second commit_req while busy is dropped.
- In SEQ_RUN, stop_req, then pulse carr_evt_x for channels 0-7 with ch5 period=0 and ch5 never pulsed -> SEQ_IDLE after the last required event; pwm_onoff=0; timeout_err=0.
- Stop with DRAIN_TIMEOUT=100 and no carr_evt_x -> SEQ_IDLE after 100 cycles; timeout_err=1; timeout_err clears on the next start_req.
- Assert reset=0 mid-DRAIN with pending=8'hFF -> outputs 0, seq_state SEQ_IDLE, commit_busy 0 asynchronously.

Source files
------------

// File: rtl/pwm_cfg_sequencer_pkg.sv
// Shared types and defaults for the PWM configuration sequencer and its channels.
package pwm_cfg_sequencer_pkg;

  localparam int PWM_WIDTH_DEF      = 8;
  localparam int PWMCOUNT_WIDTH_DEF = 16;
  localparam int DRAIN_TIMEOUT_DEF  = 65535;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_START = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_DRAIN = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    FLD_PERIOD   = 2'd0,
    FLD_COMPARE  = 2'd1,
    FLD_INITCARR = 2'd2,
    FLD_RSVD     = 2'd3
  } cfg_field_e;

endpackage

// File: rtl/pwm_cfg_channel.sv
// One carrier channel: shadow triple written by software, active triple fed to the
// PWM core, and the pending flag that marks a committed-but-not-yet-applied shadow.
module pwm_cfg_channel
  import pwm_cfg_sequencer_pkg::*;
#(
  parameter int CW = PWMCOUNT_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [1:0]    wr_field_i,
  input  logic [CW-1:0] wr_data_i,
  input  logic          commit_set_i,
  input  logic          apply_i,
  output logic          pending_o,
  output logic          pending_nxt_o,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] compare_o,
  output logic [CW-1:0] initcarr_o
);

  logic [CW-1:0] sh_period_q, sh_period_d;
  logic [CW-1:0] sh_compare_q, sh_compare_d;
  logic [CW-1:0] sh_initcarr_q, sh_initcarr_d;
  logic [CW-1:0] act_period_q, act_period_d;
  logic [CW-1:0] act_compare_q, act_compare_d;
  logic [CW-1:0] act_initcarr_q, act_initcarr_d;
  logic          pend_q, pend_d;

  // Apply copies the pre-edge shadow, so a write landing on the same edge waits for the next commit.
  always_comb begin
    sh_period_d    = sh_period_q;
    sh_compare_d   = sh_compare_q;
    sh_initcarr_d  = sh_initcarr_q;
    act_period_d   = act_period_q;
    act_compare_d  = act_compare_q;
    act_initcarr_d = act_initcarr_q;
    pend_d         = pend_q;
    if (wr_en_i) begin
      case (cfg_field_e'(wr_field_i))
        FLD_PERIOD:   sh_period_d   = wr_data_i;
        FLD_COMPARE:  sh_compare_d  = wr_data_i;
        FLD_INITCARR: sh_initcarr_d = wr_data_i;
        default:      sh_period_d   = sh_period_q;
      endcase
    end else begin
      sh_period_d = sh_period_q;
    end
    if (apply_i) begin
      act_period_d   = sh_period_q;
      act_compare_d  = sh_compare_q;
      act_initcarr_d = sh_initcarr_q;
    end else begin
      act_period_d   = act_period_q;
    end
    if (commit_set_i) begin
      pend_d = 1'b1;
    end else if (apply_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_period_q    <= '0;
      sh_compare_q   <= '0;
      sh_initcarr_q  <= '0;
      act_period_q   <= '0;
      act_compare_q  <= '0;
      act_initcarr_q <= '0;
      pend_q         <= 1'b0;
    end else begin
      sh_period_q    <= sh_period_d;
      sh_compare_q   <= sh_compare_d;
      sh_initcarr_q  <= sh_initcarr_d;
      act_period_q   <= act_period_d;
      act_compare_q  <= act_compare_d;
      act_initcarr_q <= act_initcarr_d;
      pend_q         <= pend_d;
    end
  end

  assign pending_o     = pend_q;
  assign pending_nxt_o = pend_d;
  assign period_o      = act_period_q;
  assign compare_o     = act_compare_q;
  assign initcarr_o    = act_initcarr_q;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// PWM run-time configuration sequencer: shadow/active commit per channel plus the
// start / run / drain-to-carrier-boundary control FSM.
module pwm_cfg_sequencer
  import pwm_cfg_sequencer_pkg::*;
#(
  parameter int PWM_WIDTH      = PWM_WIDTH_DEF,
  parameter int PWMCOUNT_WIDTH = PWMCOUNT_WIDTH_DEF,
  parameter int DRAIN_TIMEOUT  = DRAIN_TIMEOUT_DEF,
  localparam int CHW  = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1,
  localparam int CNTW = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [CHW-1:0]                      wr_chan,
  input  logic [1:0]                          wr_field,
  input  logic [PWMCOUNT_WIDTH-1:0]           wr_data,
  input  logic                                commit_req,
  input  logic [PWM_WIDTH-1:0]                commit_mask,
  output logic                                commit_busy,
  output logic                                commit_done,
  input  logic                                start_req,
  input  logic                                stop_req,
  input  logic [PWM_WIDTH-1:0]                carr_evt_x,
  output logic [PWMCOUNT_WIDTH*PWM_WIDTH-1:0] period_x,
  output logic [PWMCOUNT_WIDTH*PWM_WIDTH-1:0] compare_x,
  output logic [PWMCOUNT_WIDTH*PWM_WIDTH-1:0] initcarr_x,
  output logic                                pwm_onoff,
  output logic [1:0]                          seq_state,
  output logic                                timeout_err
);

  seq_state_e            state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0]  seen_q, seen_d;
  logic                  onoff_q, onoff_d;
  logic                  terr_q, terr_d;
  logic                  done_q, done_d;

  logic [PWM_WIDTH-1:0]  pend_s, pend_nxt_s, apply_s, commit_set_s, wr_en_s, zero_per_s;
  logic                  commit_acc_s;

  assign wr_ready     = ~pend_s[wr_chan];
  assign commit_busy  = |pend_s;
  assign commit_acc_s = commit_req & ~commit_busy;

  for (genvar i = 0; i < PWM_WIDTH; i++) begin : g_chan
    localparam logic [CHW-1:0] CH_IDX = CHW'(i);

    assign wr_en_s[i]      = wr_valid & wr_ready & (wr_chan == CH_IDX);
    assign commit_set_s[i] = commit_acc_s & commit_mask[i];
    // START force-loads every channel; RUN waits for that channel's carrier event; DRAIN holds.
    assign apply_s[i] = (state_q == SEQ_START) |
                        (pend_s[i] & ((state_q == SEQ_IDLE) |
                                      ((state_q == SEQ_RUN) & carr_evt_x[i])));
    assign zero_per_s[i] = (period_x[PWMCOUNT_WIDTH*i +: PWMCOUNT_WIDTH] == '0);

    pwm_cfg_channel #(.CW(PWMCOUNT_WIDTH)) u_chan (
      .clk           (clk),
      .reset         (reset),
      .wr_en_i       (wr_en_s[i]),
      .wr_field_i    (wr_field),
      .wr_data_i     (wr_data),
      .commit_set_i  (commit_set_s[i]),
      .apply_i       (apply_s[i]),
      .pending_o     (pend_s[i]),
      .pending_nxt_o (pend_nxt_s[i]),
      .period_o      (period_x[PWMCOUNT_WIDTH*i +: PWMCOUNT_WIDTH]),
      .compare_o     (compare_x[PWMCOUNT_WIDTH*i +: PWMCOUNT_WIDTH]),
      .initcarr_o    (initcarr_x[PWMCOUNT_WIDTH*i +: PWMCOUNT_WIDTH])
    );
  end

  // Sequencer next-state, drain tracking and commit-done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    onoff_d = onoff_q;
    terr_d  = terr_q;
    done_d  = ((|pend_s) & ~(|pend_nxt_s)) | (commit_acc_s & ~(|commit_mask));
    case (state_q)
      SEQ_IDLE: begin
        if (start_req) begin
          state_d = SEQ_START;
          terr_d  = 1'b0;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_START: begin
        state_d = SEQ_RUN;
        onoff_d = 1'b1;
      end
      SEQ_RUN: begin
        if (stop_req) begin
          state_d = SEQ_DRAIN;
          cnt_d   = '0;
          seen_d  = zero_per_s;
        end else begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_DRAIN: begin
        seen_d = seen_q | carr_evt_x;
        cnt_d  = cnt_q + CNTW'(1);
        if (&seen_d) begin
          state_d = SEQ_IDLE;
          onoff_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_d == CNTW'(DRAIN_TIMEOUT)) begin
          state_d = SEQ_IDLE;
          onoff_d = 1'b0;
          terr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = SEQ_DRAIN;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        onoff_d = 1'b0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      onoff_q <= 1'b0;
      terr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      onoff_q <= onoff_d;
      terr_q  <= terr_d;
      done_q  <= done_d;
    end
  end

  assign pwm_onoff   = onoff_q;
  assign seq_state   = state_q;
  assign timeout_err = terr_q;
  assign commit_done = done_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Randomised scenario bench for pwm_cfg_sequencer against a shadow/active array model.
module tb_pwm_cfg_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_valid = 1'b0, wr_ready;
  logic [2:0]   wr_chan = '0;
  logic [1:0]   wr_field = '0;
  logic [15:0]  wr_data = '0;
  logic         commit_req = 1'b0, commit_busy, commit_done;
  logic [7:0]   commit_mask = '0;
  logic         start_req = 1'b0, stop_req = 1'b0;
  logic [7:0]   carr_evt_x = '0;
  logic [127:0] period_x, compare_x, initcarr_x;
  logic         pwm_onoff, timeout_err;
  logic [1:0]   seq_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sh  [8][3];
  logic [15:0] act [8][3];
  logic [15:0] newp4;

  always #5 clk = ~clk;

  pwm_cfg_sequencer #(.DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_field(wr_field),
    .wr_data(wr_data), .commit_req(commit_req), .commit_mask(commit_mask),
    .commit_busy(commit_busy), .commit_done(commit_done),
    .start_req(start_req), .stop_req(stop_req), .carr_evt_x(carr_evt_x),
    .period_x(period_x), .compare_x(compare_x), .initcarr_x(initcarr_x),
    .pwm_onoff(pwm_onoff), .seq_state(seq_state), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int fld, input logic [15:0] d);
    wr_valid = 1'b1; wr_chan = 3'(ch); wr_field = 2'(fld); wr_data = d;
    tick();
    wr_valid = 1'b0;
    if (fld < 3) sh[ch][fld] = d;
  endtask

  task automatic do_commit(input logic [7:0] m);
    commit_req = 1'b1; commit_mask = m;
    tick();
    commit_req = 1'b0; commit_mask = '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) begin sh[c][f] = '0; act[c][f] = '0; end
    reset = 1'b0;
    tick(); tick();
    n_checks++; if ({period_x, compare_x, initcarr_x} !== '0) begin n_fail++; $display("FAIL reset_active got nonzero required 0"); end
    n_checks++; if ({pwm_onoff, seq_state, commit_busy, commit_done, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b required 000000", {pwm_onoff, seq_state, commit_busy, commit_done, timeout_err}); end
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_idle_commit();
    logic [15:0] d;
    do_write(0, 0, 16'd2000); do_write(0, 1, 16'd500); do_write(0, 2, 16'd1000);
    do_write(0, 3, 16'($urandom));
    for (int c = 1; c < 8; c++) do_write(c, $urandom_range(0, 2), 16'($urandom));
    n_checks++; if (period_x !== '0) begin n_fail++; $display("FAIL write_no_active got %h required 0", period_x); end
    do_commit(8'h01);
    n_checks++; if (commit_busy !== 1'b1) begin n_fail++; $display("FAIL idle_busy got %b required 1", commit_busy); end
    tick();
    act[0] = sh[0];
    n_checks++; if (period_x[15:0] !== 16'd2000) begin n_fail++; $display("FAIL idle_period got %0d required 2000", period_x[15:0]); end
    n_checks++; if (compare_x[15:0] !== 16'd500 || initcarr_x[15:0] !== 16'd1000) begin
      n_fail++; $display("FAIL idle_cmp_init got %0d/%0d required 500/1000", compare_x[15:0], initcarr_x[15:0]); end
    n_checks++; if (commit_done !== 1'b1 || commit_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_done got done=%b busy=%b required 1/0", commit_done, commit_busy); end
    tick();
    n_checks++; if (commit_done !== 1'b0 || pwm_onoff !== 1'b0) begin
      n_fail++; $display("FAIL idle_done_once got done=%b onoff=%b required 0/0", commit_done, pwm_onoff); end
    do_commit(8'h00);
    n_checks++; if (commit_done !== 1'b1) begin n_fail++; $display("FAIL mask0_done got %b required 1", commit_done); end
    tick();
    n_checks++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL mask0_once got %b required 0", commit_done); end
    // write and commit on the same edge: commit must carry the new value
    d = 16'($urandom_range(1, 65535));
    wr_valid = 1'b1; wr_chan = 3'd1; wr_field = 2'd0; wr_data = d;
    commit_req = 1'b1; commit_mask = 8'h02;
    tick();
    wr_valid = 1'b0; commit_req = 1'b0; commit_mask = '0;
    sh[1][0] = d;
    tick();
    act[1] = sh[1];
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (period_x[16*c +: 16] !== act[c][0] || compare_x[16*c +: 16] !== act[c][1] || initcarr_x[16*c +: 16] !== act[c][2]) begin
        n_fail++; $display("FAIL idle_act_ch%0d got %h/%h/%h required %h/%h/%h", c, period_x[16*c +: 16],
          compare_x[16*c +: 16], initcarr_x[16*c +: 16], act[c][0], act[c][1], act[c][2]); end
    end
  endtask

  task automatic test_start();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 3; f++)
        do_write(c, f, (c == 5 && f == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    n_checks++; if (seq_state !== S_START || pwm_onoff !== 1'b0) begin
      n_fail++; $display("FAIL start_n1 got state=%0d onoff=%b required 1/0", seq_state, pwm_onoff); end
    tick();
    n_checks++; if (seq_state !== S_RUN || pwm_onoff !== 1'b1) begin
      n_fail++; $display("FAIL start_n2 got state=%0d onoff=%b required 2/1", seq_state, pwm_onoff); end
    for (int c = 0; c < 8; c++) begin
      act[c] = sh[c];
      n_checks++;
      if (period_x[16*c +: 16] !== act[c][0] || compare_x[16*c +: 16] !== act[c][1] || initcarr_x[16*c +: 16] !== act[c][2]) begin
        n_fail++; $display("FAIL start_act_ch%0d got %h/%h/%h required %h/%h/%h", c, period_x[16*c +: 16],
          compare_x[16*c +: 16], initcarr_x[16*c +: 16], act[c][0], act[c][1], act[c][2]); end
    end
  endtask

  task automatic test_run_commit();
    logic [15:0] old3;
    old3 = act[3][1];
    do_write(3, 1, 16'd700);
    do_commit(8'h08);
    wr_chan = 3'd3;
    #1;
    n_checks++; if (wr_ready !== 1'b0 || commit_busy !== 1'b1) begin
      n_fail++; $display("FAIL run_pending got ready=%b busy=%b required 0/1", wr_ready, commit_busy); end
    newp4 = 16'($urandom_range(1, 65535));
    if (newp4 == act[4][0]) newp4 = newp4 ^ 16'h8000;
    do_write(4, 0, newp4);
    do_commit(8'h10);
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (compare_x[63:48] !== old3) begin n_fail++; $display("FAIL run_hold got %0d required %0d", compare_x[63:48], old3); end
    carr_evt_x = 8'h10;
    tick();
    carr_evt_x = '0;
    n_checks++; if (period_x[79:64] !== act[4][0]) begin n_fail++; $display("FAIL run_drop got %0d required %0d", period_x[79:64], act[4][0]); end
    carr_evt_x = 8'h08;
    tick();
    carr_evt_x = '0;
    act[3][1] = 16'd700;
    n_checks++; if (compare_x[63:48] !== 16'd700) begin n_fail++; $display("FAIL run_apply got %0d required 700", compare_x[63:48]); end
    n_checks++; if (commit_done !== 1'b1 || commit_busy !== 1'b0) begin
      n_fail++; $display("FAIL run_done got done=%b busy=%b required 1/0", commit_done, commit_busy); end
    do_commit(8'h10);
  endtask

  task automatic test_drain_events();
    int order [7];
    int n, j, t;
    n = 0;
    for (int c = 0; c < 8; c++) if (c != 5) begin order[n] = c; n++; end
    for (int i = 6; i > 0; i--) begin j = $urandom_range(0, i); t = order[i]; order[i] = order[j]; order[j] = t; end
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    n_checks++; if (seq_state !== S_DRAIN || pwm_onoff !== 1'b1) begin
      n_fail++; $display("FAIL drain_entry got state=%0d onoff=%b required 3/1", seq_state, pwm_onoff); end
    for (int i = 0; i < 7; i++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
      carr_evt_x = 8'(1 << order[i]);
      tick();
      carr_evt_x = '0;
      n_checks++;
      if (seq_state !== ((i == 6) ? S_IDLE : S_DRAIN)) begin
        n_fail++; $display("FAIL drain_step%0d got state=%0d required %0d", i, seq_state, (i == 6) ? S_IDLE : S_DRAIN); end
    end
    n_checks++; if (pwm_onoff !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL drain_exit got onoff=%b terr=%b required 0/0", pwm_onoff, timeout_err); end
    n_checks++; if (period_x[79:64] !== act[4][0] || commit_busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_held got %0d busy=%b required %0d/1", period_x[79:64], commit_busy, act[4][0]); end
    tick();
    act[4] = sh[4];
    n_checks++; if (period_x[79:64] !== newp4 || commit_done !== 1'b1) begin
      n_fail++; $display("FAIL idle_apply got %0d done=%b required %0d/1", period_x[79:64], commit_done, newp4); end
    n_checks++; if (period_x[95:80] !== 16'd0) begin n_fail++; $display("FAIL zero_period got %0d required 0", period_x[95:80]); end
  endtask

  task automatic test_timeout();
    int n;
    start_req = 1'b1; tick(); start_req = 1'b0; tick();
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    n = 0;
    while (seq_state == S_DRAIN && n < 3 * TMO) begin tick(); n++; end
    n_checks++; if (n != TMO) begin n_fail++; $display("FAIL timeout_cycles got %0d required %0d", n, TMO); end
    n_checks++; if (seq_state !== S_IDLE || timeout_err !== 1'b1 || pwm_onoff !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags got state=%0d terr=%b onoff=%b required 0/1/0", seq_state, timeout_err, pwm_onoff); end
    start_req = 1'b1; tick(); start_req = 1'b0;
    n_checks++; if (timeout_err !== 1'b0 || seq_state !== S_START) begin
      n_fail++; $display("FAIL timeout_clear got terr=%b state=%0d required 0/1", timeout_err, seq_state); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    do_commit(8'hFF);
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    n_checks++; if (seq_state !== S_DRAIN || commit_busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got state=%0d busy=%b required 3/1", seq_state, commit_busy); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({period_x, compare_x, initcarr_x} !== '0) begin n_fail++; $display("FAIL async_reset_active got nonzero required 0"); end
    n_checks++; if ({pwm_onoff, seq_state, commit_busy, commit_done, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL async_reset_ctrl got %b required 000000", {pwm_onoff, seq_state, commit_busy, commit_done, timeout_err}); end
    tick();
    #2 reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_commit();
    test_start();
    test_run_commit();
    test_drain_events();
    test_timeout();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
